// File: rtl/alp_pkg.sv
// Shared definitions for the ALP multiply/divide sequencer.
// Holds the sequencer state encoding and the operation codes.
package alp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic ALP_OP_MUL = 1'b0;
  localparam logic ALP_OP_DIV = 1'b1;

endpackage

// File: rtl/alp_mdstep.sv
// One combinational iteration of the sequencer: a shift-add multiply step
// or a restoring shift-subtract divide step on the D/Q register pair.
module alp_mdstep
  import alp_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             op,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] m,
  output logic [WIDTH-1:0] d_next,
  output logic [WIDTH-1:0] q_next
);

  logic [WIDTH:0] addend_s;
  logic [WIDTH:0] sum_s;
  logic [WIDTH:0] trial_s;
  logic [WIDTH:0] diff_s;
  logic           borrow_s;

  // Both step flavours are computed every cycle; op selects which one is used.
  always_comb begin
    addend_s = q[0] ? {1'b0, m} : {(WIDTH + 1){1'b0}};
    sum_s    = {1'b0, d} + addend_s;
    trial_s  = {d, q[WIDTH-1]};
    diff_s   = trial_s - {1'b0, m};
    borrow_s = (trial_s < {1'b0, m});
    d_next   = d;
    q_next   = q;
    if (op == ALP_OP_MUL) begin
      d_next = sum_s[WIDTH:1];
      q_next = {sum_s[0], q[WIDTH-1:1]};
    end else if (!borrow_s) begin
      d_next = diff_s[WIDTH-1:0];
      q_next = {q[WIDTH-2:0], 1'b1};
    end else begin
      d_next = trial_s[WIDTH-1:0];
      q_next = {q[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/alp_mdseq.sv
// WIDTH-bit multiply/divide sequencer: one shift-add or shift-subtract step
// per clock under a start/busy/done handshake, results in the D/Q pair.
module alp_mdseq
  import alp_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_h,
  input  logic             rst_h,
  input  logic             start_h,
  input  logic             op_h,
  input  logic             abort_h,
  input  logic [WIDTH-1:0] a_h,
  input  logic [WIDTH-1:0] b_h,
  output logic             busy_h,
  output logic             done_h,
  output logic [WIDTH-1:0] hi_h,
  output logic [WIDTH-1:0] lo_h,
  output logic             dz_h,
  output logic             zero_h
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t           state_r;
  state_t           state_s;
  logic [WIDTH-1:0] d_r;
  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] m_r;
  logic [WIDTH-1:0] d_step_s;
  logic [WIDTH-1:0] q_step_s;
  logic [CNT_W-1:0] cnt_r;
  logic             op_r;
  logic             dz_r;
  logic             accept_s;
  logic             div0_s;
  logic             last_s;

  assign accept_s = start_h & ~abort_h & ((state_r == ST_IDLE) | (state_r == ST_DONE));
  assign div0_s   = (op_h == ALP_OP_DIV) & (b_h == {WIDTH{1'b0}});
  assign last_s   = (cnt_r == CNT_W'(1));

  alp_mdstep #(
    .WIDTH (WIDTH)
  ) u_step (
    .op     (op_r),
    .d      (d_r),
    .q      (q_r),
    .m      (m_r),
    .d_next (d_step_s),
    .q_next (q_step_s)
  );

  // State register.
  always_ff @(posedge clk_h or posedge rst_h) begin
    if (rst_h) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; abort wins over both start and the final step.
  always_comb begin
    state_s = ST_IDLE;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (accept_s) begin
          state_s = div0_s ? ST_DONE : ST_RUN;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (abort_h) begin
          state_s = ST_IDLE;
        end else if (last_s) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_RUN;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Output decode from the state register and the result pair.
  always_comb begin
    busy_h = 1'b0;
    done_h = 1'b0;
    case (state_r)
      ST_RUN:  busy_h = 1'b1;
      ST_DONE: done_h = 1'b1;
      default: begin
        busy_h = 1'b0;
        done_h = 1'b0;
      end
    endcase
    zero_h = (d_r == {WIDTH{1'b0}}) & (q_r == {WIDTH{1'b0}});
  end

  // Operand load on accept, one iteration per RUN cycle; abort freezes D/Q.
  always_ff @(posedge clk_h or posedge rst_h) begin
    if (rst_h) begin
      d_r   <= {WIDTH{1'b0}};
      q_r   <= {WIDTH{1'b0}};
      m_r   <= {WIDTH{1'b0}};
      cnt_r <= {CNT_W{1'b0}};
      op_r  <= ALP_OP_MUL;
      dz_r  <= 1'b0;
    end else if (accept_s) begin
      op_r <= op_h;
      m_r  <= b_h;
      if (div0_s) begin
        d_r   <= a_h;
        q_r   <= {WIDTH{1'b1}};
        cnt_r <= {CNT_W{1'b0}};
        dz_r  <= 1'b1;
      end else begin
        d_r   <= {WIDTH{1'b0}};
        q_r   <= a_h;
        cnt_r <= CNT_W'(WIDTH);
        dz_r  <= 1'b0;
      end
    end else if ((state_r == ST_RUN) && !abort_h) begin
      d_r   <= d_step_s;
      q_r   <= q_step_s;
      cnt_r <= cnt_r - CNT_W'(1);
    end else begin
      d_r   <= d_r;
      q_r   <= q_r;
      cnt_r <= cnt_r;
    end
  end

  assign hi_h = d_r;
  assign lo_h = q_r;
  assign dz_h = dz_r;

endmodule
